// File: rtl/regfile_wr_sched_if.sv
// Writeback-side bus of the register-file write scheduler: requester handshakes,
// clear-sweep control and the WE3/WA3/WD3 write port.
interface regfile_wr_sched_if #(
    parameter int unsigned bits  = 16,
    parameter int unsigned N     = 3,
    parameter int unsigned N_REQ = 3
);
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ*N-1:0]    req_addr;
    logic [N_REQ*bits-1:0] req_data;
    logic [N_REQ-1:0]      req_ready;
    logic                  clr_req;
    logic                  clr_busy;
    logic                  clr_done;
    logic                  we_o;
    logic [N-1:0]          wa_o;
    logic [bits-1:0]       wd_o;

    modport master (
        output req_valid, req_addr, req_data, clr_req,
        input  req_ready, clr_busy, clr_done, we_o, wa_o, wd_o
    );

    modport slave (
        input  req_valid, req_addr, req_data, clr_req,
        output req_ready, clr_busy, clr_done, we_o, wa_o, wd_o
    );
endinterface

// File: rtl/regfile_wr_sched.sv
// Round-robin scheduler for the single register-file write port, with a
// clear sequencer that zeroes every register on request.
module regfile_wr_sched #(
    parameter int unsigned bits  = 16,
    parameter int unsigned N     = 3,
    parameter int unsigned N_REQ = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wr_sched_if.slave    bus
);
    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PW:0]   NREQ_W   = N_REQ[PW:0];
    localparam logic [PW-1:0] LAST_REQ = PW'(N_REQ - 1);
    localparam logic [N:0]    CNT_LAST = {1'b0, {N{1'b1}}};

    typedef enum logic {ARB, CLEAR} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_rr_ptr;
    logic [N:0]      r_cnt;
    logic            r_we;
    logic [N-1:0]    r_wa;
    logic [bits-1:0] r_wd;
    logic            r_clr_done;

    logic [PW:0]     w_cand;
    logic [PW-1:0]   w_grant_idx;
    logic            w_grant_any;
    logic [N_REQ-1:0] w_ready;
    logic            w_xfer;
    logic            w_last;
    logic            w_clr_busy;
    logic [N-1:0]    w_sel_addr;
    logic [bits-1:0] w_sel_data;

    assign w_last = (r_cnt == CNT_LAST);

    // Rotating priority search starting at r_rr_ptr, wrapping past N_REQ-1.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_cand = {1'b0, r_rr_ptr} + k[PW:0];
            if (w_cand >= NREQ_W)
                w_cand = w_cand - NREQ_W;
            if (!w_grant_any && bus.req_valid[w_cand[PW-1:0]]) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_cand[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ARB;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB:     if (bus.clr_req) w_state_nxt = CLEAR;
            CLEAR:   if (w_last)      w_state_nxt = ARB;
            default: w_state_nxt = ARB;
        endcase
    end

    always_comb begin
        w_ready    = '0;
        w_clr_busy = (r_state == CLEAR);
        if (!rst && r_state == ARB && !bus.clr_req && w_grant_any)
            w_ready[w_grant_idx] = 1'b1;
        w_xfer     = |w_ready;
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (w_ready[k]) begin
                w_sel_addr = bus.req_addr[k*N +: N];
                w_sel_data = bus.req_data[k*bits +: bits];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_wa       <= '0;
            r_wd       <= '0;
            r_clr_done <= 1'b0;
        end else if (r_state == CLEAR) begin
            r_we       <= 1'b1;
            r_wa       <= r_cnt[N-1:0];
            r_wd       <= '0;
            r_clr_done <= w_last;
            r_cnt      <= r_cnt + 1'b1;
        end else begin
            r_clr_done <= 1'b0;
            r_cnt      <= '0;
            r_we       <= w_xfer;
            if (w_xfer) begin
                r_wa     <= w_sel_addr;
                r_wd     <= w_sel_data;
                r_rr_ptr <= (w_grant_idx == LAST_REQ) ? '0 : w_grant_idx + 1'b1;
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.clr_busy  = w_clr_busy;
    assign bus.clr_done  = r_clr_done;
    assign bus.we_o      = r_we;
    assign bus.wa_o      = r_wa;
    assign bus.wd_o      = r_wd;
endmodule

// File: tb/tb_regfile_wr_sched.sv
// Directed bench for regfile_wr_sched: table of per-cycle vectors plus
// hand-written clear-sweep and reset-abort sequences.
module tb_regfile_wr_sched;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    regfile_wr_sched_if #(.bits(16), .N(3), .N_REQ(3)) bus ();

    regfile_wr_sched #(.bits(16), .N(3), .N_REQ(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [2:0]  valid;
        logic        clr;
        logic [2:0]  ready;
        logic        busy;
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        done;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // req0 -> addr 0 / 1111, req1 -> addr 3 / BEEF, req2 -> addr 6 / 2222
        bus.req_addr  = {3'd6, 3'd3, 3'd0};
        bus.req_data  = {16'h2222, 16'hBEEF, 16'h1111};
        bus.req_valid = 3'b111;
        bus.clr_req   = 1'b1;
        rst           = 1'b1;

        //               rst valid  clr ready  busy we wa    wd        done
        vecs[0]  = '{1'b1, 3'b111, 1'b1, 3'b000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0};
        vecs[1]  = '{1'b0, 3'b010, 1'b0, 3'b010, 1'b0, 1'b1, 3'd3, 16'hBEEF, 1'b0};
        vecs[2]  = '{1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 3'd3, 16'hBEEF, 1'b0};
        vecs[3]  = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0};
        vecs[4]  = '{1'b0, 3'b111, 1'b0, 3'b001, 1'b0, 1'b1, 3'd0, 16'h1111, 1'b0};
        vecs[5]  = '{1'b0, 3'b111, 1'b0, 3'b010, 1'b0, 1'b1, 3'd3, 16'hBEEF, 1'b0};
        vecs[6]  = '{1'b0, 3'b111, 1'b0, 3'b100, 1'b0, 1'b1, 3'd6, 16'h2222, 1'b0};
        vecs[7]  = '{1'b0, 3'b111, 1'b0, 3'b001, 1'b0, 1'b1, 3'd0, 16'h1111, 1'b0};
        vecs[8]  = '{1'b0, 3'b111, 1'b0, 3'b010, 1'b0, 1'b1, 3'd3, 16'hBEEF, 1'b0};
        vecs[9]  = '{1'b0, 3'b111, 1'b0, 3'b100, 1'b0, 1'b1, 3'd6, 16'h2222, 1'b0};
        vecs[10] = '{1'b0, 3'b100, 1'b0, 3'b100, 1'b0, 1'b1, 3'd6, 16'h2222, 1'b0};
        vecs[11] = '{1'b0, 3'b110, 1'b0, 3'b010, 1'b0, 1'b1, 3'd3, 16'hBEEF, 1'b0};
        vecs[12] = '{1'b0, 3'b100, 1'b0, 3'b100, 1'b0, 1'b1, 3'd6, 16'h2222, 1'b0};
        vecs[13] = '{1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 3'd6, 16'h2222, 1'b0};

        tick();
        for (int i = 0; i < 14; i++) begin
            rst           = vecs[i].rst;
            bus.req_valid = vecs[i].valid;
            bus.clr_req   = vecs[i].clr;
            #4;
            chk($sformatf("v%0d ready", i), {13'd0, bus.req_ready}, {13'd0, vecs[i].ready});
            chk($sformatf("v%0d busy", i),  {15'd0, bus.clr_busy},  {15'd0, vecs[i].busy});
            tick();
            chk($sformatf("v%0d we", i),   {15'd0, bus.we_o},     {15'd0, vecs[i].we});
            chk($sformatf("v%0d wa", i),   {13'd0, bus.wa_o},     {13'd0, vecs[i].wa});
            chk($sformatf("v%0d wd", i),   bus.wd_o,              vecs[i].wd);
            chk($sformatf("v%0d done", i), {15'd0, bus.clr_done}, {15'd0, vecs[i].done});
        end

        // Sweep with req0 pending: cycle T has clr_req=1.
        rst           = 1'b0;
        bus.req_valid = 3'b001;
        bus.clr_req   = 1'b1;
        #4;
        chk("sweep T ready", {13'd0, bus.req_ready}, 16'd0);
        tick();
        bus.clr_req = 1'b0;
        chk("sweep T+1 we", {15'd0, bus.we_o}, 16'd0);
        for (int k = 1; k <= 8; k++) begin
            #4;
            chk($sformatf("sweep T+%0d ready", k), {13'd0, bus.req_ready}, 16'd0);
            chk($sformatf("sweep T+%0d busy", k),  {15'd0, bus.clr_busy},  16'd1);
            tick();
            chk($sformatf("sweep T+%0d we", k + 1),   {15'd0, bus.we_o},     16'd1);
            chk($sformatf("sweep T+%0d wa", k + 1),   {13'd0, bus.wa_o},     16'(k - 1));
            chk($sformatf("sweep T+%0d wd", k + 1),   bus.wd_o,              16'h0000);
            chk($sformatf("sweep T+%0d done", k + 1), {15'd0, bus.clr_done}, (k == 8) ? 16'd1 : 16'd0);
        end
        #4;
        chk("sweep T+9 ready", {13'd0, bus.req_ready}, 16'b001);
        chk("sweep T+9 busy",  {15'd0, bus.clr_busy},  16'd0);
        tick();
        bus.req_valid = 3'b000;
        chk("sweep T+10 we",   {15'd0, bus.we_o},     16'd1);
        chk("sweep T+10 wa",   {13'd0, bus.wa_o},     16'd0);
        chk("sweep T+10 wd",   bus.wd_o,              16'h1111);
        chk("sweep T+10 done", {15'd0, bus.clr_done}, 16'd0);

        // Reset abort: rst asserted in the cycle where wa_o=4.
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("abort wa at rst", {13'd0, bus.wa_o}, 16'd4);
        chk("abort we at rst", {15'd0, bus.we_o}, 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort we after", {15'd0, bus.we_o},     16'd0);
        chk("abort busy",     {15'd0, bus.clr_busy}, 16'd0);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("abort idle%0d we", k),   {15'd0, bus.we_o},     16'd0);
            chk($sformatf("abort idle%0d done", k), {15'd0, bus.clr_done}, 16'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
